// File: rtl/spi_slave.sv
// SPI mode-0 slave, LSB first, with a one-word transmit holding register.
// SPI pins are synchronised into the clk domain and all shifting is driven by detected sclk/cs edges.
module spi_slave #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CPU_SYNC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CPU_SYNC-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                sclk_d, cs_d;
    logic                sclk_s, cs_s, mosi_s;
    logic                sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [WIDTH-1:0] tx_hold;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [CNT_W-1:0] bit_cnt;

    logic word_start, shift_en, drive_en, frame_end, abort_err;

    // Input synchronisers plus one extra delay stage for edge detection; cs resets high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[CPU_SYNC-2:0], sclk};
            cs_sync   <= {cs_sync[CPU_SYNC-2:0], cs};
            mosi_sync <= {mosi_sync[CPU_SYNC-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[CPU_SYNC-1];
    assign cs_s      = cs_sync[CPU_SYNC-1];
    assign mosi_s    = mosi_sync[CPU_SYNC-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign rx_next   = {mosi_s, rx_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes decoded from the current state and the synchronised edges.
    always_comb begin
        word_start = 1'b0;
        shift_en   = 1'b0;
        drive_en   = 1'b0;
        frame_end  = 1'b0;
        abort_err  = 1'b0;
        case (state_q)
            IDLE: begin
                word_start = cs_fall;
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_end = 1'b1;
                    abort_err = (bit_cnt != '0) && (bit_cnt != CNT_FULL);
                end else begin
                    shift_en = sclk_rise && (bit_cnt != CNT_FULL);
                    if (sclk_fall) begin
                        if (bit_cnt == CNT_FULL) begin
                            word_start = 1'b1;
                        end else if (bit_cnt != '0) begin
                            drive_en = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Shift datapath; an empty holding register at word start sends zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            miso        <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= abort_err;
            busy        <= (state_d == SHIFT);
            if (word_start) begin
                tx_shift    <= tx_ready ? '0 : tx_hold;
                miso        <= tx_ready ? 1'b0 : tx_hold[0];
                bit_cnt     <= '0;
                tx_underrun <= tx_ready;
            end else if (frame_end) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                if (shift_en) begin
                    rx_shift <= rx_next[WIDTH-1:1];
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_LAST) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                    end
                end
                if (drive_en) begin
                    miso <= tx_shift[IDX_W'(bit_cnt)];
                end
            end
        end
    end

    // Holding register: a load in the same cycle as an empty word start is kept for the next word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_hold  <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (tx_load && tx_ready) begin
                tx_hold <= tx_data;
            end
            if (word_start && !tx_ready) begin
                tx_ready <= 1'b1;
            end else if (tx_load && tx_ready) begin
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: a bit-banged SPI master, a transaction-level
// model of the holding register, and a scoreboard monitor for received words.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_load = 1'b0;
    logic       miso, tx_ready, rx_valid, busy, tx_underrun, frame_err;
    logic [7:0] rx_data;

    spi_slave #(.WIDTH(8), .CPU_SYNC(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] tx_model[$];
    logic [7:0] last_rx = '0;
    int exp_underrun = 0, seen_underrun = 0;
    int exp_ferr = 0, seen_ferr = 0;
    int exp_rxv = 0, seen_rxv = 0;

    logic [7:0] mw[4];
    logic [7:0] ldv[4];
    bit         ld[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rx_valid pops one expected word.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid === 1'b1) begin
                seen_rxv++;
                if (exp_rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h expected no word at %0t", rx_data, $time);
                end else begin
                    check("rx_data", rx_data, exp_rx_q.pop_front());
                end
            end
            if (tx_underrun === 1'b1) seen_underrun++;
            if (frame_err === 1'b1) seen_ferr++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Word start in the model: the master receives the held word, or zero with an underrun.
    task automatic model_word_start();
        if (tx_model.size() > 0) begin
            exp_miso_q.push_back(tx_model.pop_front());
        end else begin
            exp_miso_q.push_back(8'h00);
            exp_underrun++;
        end
    endtask

    task automatic load_word(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_wait: got %0b expected 1 within 200 cycles", tx_ready);
            return;
        end
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        tx_model.push_back(d);
        check("tx_ready_after_load", tx_ready, 0);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 4; k++) begin
            mw[k] = '0;
            ldv[k] = '0;
            ld[k] = 1'b0;
        end
    endtask

    // Master frame of nw words with cs held low; sclk stays high until cs has risen.
    task automatic run_frame(input int nw);
        logic [7:0] got;
        @(negedge clk);
        cs = 1'b0;
        mosi = mw[0][0];
        model_word_start();
        for (int w = 0; w < nw; w++) begin
            got = '0;
            for (int b = 0; b < 8; b++) begin
                repeat (HALF) @(negedge clk);
                got[b] = miso;
                if (b == 0) begin
                    check("tx_ready_after_start", tx_ready, 1);
                    check("busy_in_frame", busy, 1);
                end
                sclk = 1'b1;
                if (b == 7) begin
                    exp_rx_q.push_back(mw[w]);
                    last_rx = mw[w];
                    exp_rxv++;
                end
                if (b == 0 && w + 1 < nw && ld[w + 1]) begin
                    load_word(ldv[w + 1]);
                    repeat (HALF - 2) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                if (!(w == nw - 1 && b == 7)) begin
                    sclk = 1'b0;
                    if (b == 7) begin
                        model_word_start();
                        mosi = mw[w + 1][0];
                    end else begin
                        mosi = mw[w][b + 1];
                    end
                end
            end
            check("miso_word", got, exp_miso_q.pop_front());
        end
        cs = 1'b1;
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic run_abort(input int nb, input logic [7:0] d);
        logic [7:0] got, exp, mask;
        got = '0;
        @(negedge clk);
        cs = 1'b0;
        mosi = d[0];
        model_word_start();
        for (int b = 0; b < nb; b++) begin
            repeat (HALF) @(negedge clk);
            got[b] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            mosi = d[b + 1];
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        if (nb > 0) exp_ferr++;
        exp = exp_miso_q.pop_front();
        mask = 8'((1 << nb) - 1);
        if (nb > 0) check("abort_miso_bits", got & mask, exp & mask);
        repeat (HALF) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rx_hold", rx_data, last_rx);
        check("frame_err_count", seen_ferr, exp_ferr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tx_underrun"}, tx_underrun, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_data"}, rx_data, 0);
    endtask

    task automatic run_reset_mid_word(input logic [7:0] d);
        @(negedge clk);
        cs = 1'b0;
        mosi = d[0];
        model_word_start();
        for (int b = 0; b < 4; b++) begin
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            mosi = d[b + 1];
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        void'(exp_miso_q.pop_front());
        tx_model.delete();
        last_rx = '0;
        #4;
        cs = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_tx_ready", tx_ready, 1);
        check("post_reset_busy", busy, 0);
        check("reset_no_frame_err", seen_ferr, exp_ferr);
    endtask

    initial begin
        int nw;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        clear_plan();
        load_word(8'h03);
        mw[0] = 8'hE6;
        run_frame(1);

        clear_plan();
        load_word(8'hC3);
        mw[0] = 8'h0F;
        run_frame(1);
        check("underrun_count_loaded", seen_underrun, exp_underrun);

        clear_plan();
        load_word(8'hA5);
        mw[0] = 8'h11;
        mw[1] = 8'h22;
        ld[1] = 1'b1;
        ldv[1] = 8'h5A;
        run_frame(2);
        check("underrun_count_two_word", seen_underrun, exp_underrun);

        clear_plan();
        mw[0] = 8'($urandom);
        run_frame(1);
        check("underrun_count_empty", seen_underrun, exp_underrun);

        load_word(8'($urandom));
        run_abort(3, 8'($urandom));

        run_reset_mid_word(8'h96);
        clear_plan();
        load_word(8'h81);
        mw[0] = 8'h3C;
        run_frame(1);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) load_word(8'($urandom));
                run_abort(int'($urandom_range(0, 7)), 8'($urandom));
            end else begin
                clear_plan();
                nw = int'($urandom_range(1, 3));
                for (int k = 0; k < 4; k++) begin
                    mw[k] = 8'($urandom);
                    ldv[k] = 8'($urandom);
                    ld[k] = ($urandom_range(0, 1) == 1);
                end
                if (ld[0]) load_word(ldv[0]);
                run_frame(nw);
            end
            check("underrun_count", seen_underrun, exp_underrun);
        end

        repeat (20) @(negedge clk);
        check("rx_valid_count", seen_rxv, exp_rxv);
        check("rx_queue_empty", exp_rx_q.size(), 0);
        check("frame_err_total", seen_ferr, exp_ferr);
        check("underrun_total", seen_underrun, exp_underrun);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: WIDTH, default 8, frame word width in bits.
REQ-002 Parameter: CPU_SYNC, default 2, number of synchronizer flops on sclk, cs and mosi.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  SPI clock from master; idles low (mode 0).
REQ-006 cs  input  1  chip select from master, active-low.
REQ-007 mosi  input  1  serial data from master, LSB first.
REQ-008 miso  output  1  serial data to master, LSB first.
REQ-009 tx_data  input  WIDTH  next word to transmit.
REQ-010 tx_load  input  1  write strobe for tx_data.
REQ-011 tx_ready  output  1  tx holding register empty.
REQ-012 rx_data  output  WIDTH  last complete received word.
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 busy  output  1  frame in progress (synced cs low).
REQ-015 tx_underrun  output  1  one-cycle pulse, word started with empty holding register.
REQ-016 frame_err  output  1  one-cycle pulse, cs deasserted mid-word.

Function
REQ-017 sclk, cs and mosi SHALL each pass through CPU_SYNC flops; edges SHALL be detected by comparing the last sync stage with one further delayed flop.
REQ-018 sclk SHALL be supported only when its high and low phases each last at least 4 clk periods; faster sclk is out of scope.
REQ-019 FSM states: IDLE, SHIFT. IDLE->SHIFT on synced cs falling edge; SHIFT->IDLE on synced cs rising edge.
REQ-020 Word start (cs fall, or word boundary while cs low) SHALL copy the holding register into tx_shift, clear bit_cnt, and drive miso = tx_shift[0] the next cycle.
REQ-021 Holding register empty at word start: tx_shift = 0, tx_underrun pulses once.
REQ-022 Synced sclk rising edge in SHIFT: rx_shift <= {mosi_sync, rx_shift[WIDTH-1:1]}; bit_cnt increments.
REQ-023 Synced sclk falling edge in SHIFT with 0 < bit_cnt < WIDTH: miso <= tx_shift[bit_cnt] the next cycle.
REQ-024 On the rising edge that makes bit_cnt = WIDTH: rx_data <= completed word and rx_valid pulses high on the following cycle.
REQ-025 bit_cnt = WIDTH with cs still low: the next synced sclk falling edge SHALL perform a word start per REQ-020; multi-word frames are supported without gaps.
REQ-026 tx_load accepted only while tx_ready = 1; tx_ready SHALL fall the next cycle; tx_load while tx_ready = 0 SHALL be ignored.
REQ-027 tx_ready SHALL rise the cycle after a word start consumes the register.
REQ-028 tx_load in the same cycle as a word start with an empty register: the current word underruns (0x00), the loaded value is kept for the next word.
REQ-029 cs rising with 0 < bit_cnt < WIDTH: partial word discarded, rx_data unchanged, no rx_valid, frame_err pulses once. cs rising with bit_cnt = 0 or WIDTH: no error.
REQ-030 miso SHALL be 0 in IDLE.
REQ-031 busy SHALL be high exactly while the FSM is in SHIFT.
REQ-032 sclk edges in IDLE SHALL be ignored.

Reset
REQ-033 reset low: FSM = IDLE, immediately and without a clk edge.
REQ-034 reset low: miso, rx_valid, busy, tx_underrun, frame_err = 0; tx_ready = 1.
REQ-035 reset low: rx_data, tx_shift, rx_shift, bit_cnt = 0; sync flops cleared so that cs reads high.
REQ-036 Reset during SHIFT: the word is aborted without frame_err; after release, wait for a fresh cs falling edge.

Verification
REQ-037 tx_load 0x03, then master frame sending 0xE6 -> rx_data 0xE6 with one rx_valid pulse; master receives 0x03; tx_ready high again after word start.
REQ-038 tx_load 0xC3, then master sends 0x0F -> rx_data 0x0F; master receives 0xC3; miso bit0 = 1 valid before the first sclk rise.
REQ-039 Two-word frame with cs held low, tx 0xA5 then 0x5A loaded after tx_ready rises, master sends 0x11, 0x22 -> two rx_valid pulses (0x11, 0x22); master receives 0xA5, 0x5A; no underrun.
REQ-040 Frame with nothing loaded -> master receives 0x00; tx_underrun pulses exactly once.
REQ-041 cs raised after 3 sclk periods -> frame_err single pulse, no rx_valid, rx_data holds its previous value, busy falls.
REQ-042 reset asserted mid-word (bit_cnt 4) -> all outputs at reset values asynchronously; the next full frame 0x3C is received correctly.
